compound_rr_arbiter: RTL and testbench
======================================

Name: compound_rr_arbiter

Overview:
- Shares one CompoundType blocking consumer port among NUM_REQ producers, each using the sync/notify handshake.
- Sits in front of a single-input sequential module; selects one producer, accepts one transaction from it, then forwards that transaction downstream.
- Uses round-robin fairness, with an optional write-first priority.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
WRITE_PRIORITY, 1, if 1, requesters presenting mode==write beat mode==read requesters
ID_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_data  in  NUM_REQ x CompoundType  per-requester payload {mode, x[31:0], y}
req_sync  in  NUM_REQ  requester has valid data
req_notify  out  NUM_REQ  arbiter accepts from this requester
out_data  out  CompoundType  forwarded payload (registered)
out_sync  in  1  downstream ready to take out_data
out_notify  out  1  out_data valid
grant_id  out  ID_W  index of the requester currently owning the path
busy  out  1  high in every state except SCAN

Behaviour:
- Transfer rule: a transfer occurs on a rising clk edge where the port's sync and notify are both 1. Neither side may assume more than that.
- Reset values:
  - state=SCAN, rr_ptr=0, grant_id=0
  - req_notify=0, out_notify=0, busy=0
  - out_data={mode=read, x=0, y=0}
- FSM states: SCAN, ACCEPT, SEND.
- SCAN:
  - Build the candidate set from req_sync.
  - If WRITE_PRIORITY=1 and any candidate has mode==write, restrict the set to the write candidates.
  - Winner = first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - If no candidates, remain in SCAN.
  - Otherwise register grant_id=winner, set req_notify to one-hot(winner), and go to ACCEPT.
- ACCEPT:
  - req_notify[grant_id]=1; all other bits 0.
  - If req_sync[grant_id]=1: capture out_data<=req_data[grant_id], clear req_notify, set out_notify=1, go to SEND.
  - If req_sync[grant_id]=0 (requester withdrew): clear req_notify, return to SCAN; rr_ptr unchanged.
- SEND:
  - out_notify=1; out_data held stable.
  - On out_sync=1: clear out_notify, set rr_ptr=(grant_id+1) mod NUM_REQ, go to SCAN.
- Latency:
  - Requester sync seen in SCAN at edge n → req_notify high after edge n.
  - Capture at edge n+1 → out_notify high after edge n+1.
  - Minimum of 3 cycles per transaction (SCAN, ACCEPT, SEND).
- Fairness: within one priority class, a requester holding sync continuously is granted within NUM_REQ transactions of its class.
  - With WRITE_PRIORITY=1, reads can starve under continuous writes. This is intended.
- Payload: passed bit-exact; no arithmetic on x or y.
- rr_ptr wrap: NUM_REQ-1 → 0.
- Simultaneous events:
  - A requester's sync change during SEND is ignored until the next SCAN.
  - out_sync outside SEND has no effect.
- busy=1 in ACCEPT and SEND.
- grant_id stays valid from SCAN exit until the next winner is registered.
- Reset mid-operation:
  - Any in-flight transaction is dropped.
  - All notifies go low asynchronously; state returns to SCAN.
- Invariant: at most one req_notify bit is high in any cycle.

Decomposition:
- Shared package compound_pkg:
  - mode_t enum {read, write}
  - CompoundType struct {mode_t mode; int x; logic y}
  - arb_state_t enum {SCAN, ACCEPT, SEND}
  - reset-value constant COMPOUND_RESET
- One sub-module rr_pick (combinational, parameter N):
  - Inputs: request vector, start pointer.
  - Outputs: winner index, valid.
  - Implemented as a rotate, priority-encode, un-rotate.

Test Plan:
- Single requester: req_sync[2]=1, data {write, x=0x55, y=1}, out_sync=1 → req_notify=4'b0100 one cycle; out_data=={write,0x55,1} with out_notify one cycle later; grant_id=2; rr_ptr=3.
- All four reads held continuously, out_sync=1 → grants in order 0,1,2,3,0; each transaction takes 3 cycles.
- WRITE_PRIORITY=1: req0 read, req3 write, rr_ptr=0 → grant_id=3 first, then 0.
- Backpressure: out_sync=0 for 5 cycles in SEND → out_notify and out_data stable; all req_notify=0; no new grant; completes on out_sync=1.
- Withdrawal: req_sync[1] drops in ACCEPT → no out_notify; return to SCAN; rr_ptr unchanged; req1 re-granted first when it re-asserts.
- Async reset asserted in SEND → out_notify=0 and state=SCAN immediately; out_data={read,0,0}; the next transaction after release proceeds normally.

Source files
------------

// File: rtl/compound_pkg.sv
// compound_pkg: payload, mode and arbiter-state types shared by the arbiter slice.
package compound_pkg;
    typedef enum logic {READ, WRITE} mode_t;
    typedef struct packed {
        mode_t mode;
        int    x;
        logic  y;
    } CompoundType;
    typedef enum logic [1:0] {SCAN, ACCEPT, SEND} arb_state_t;
    localparam CompoundType COMPOUND_RESET = '{mode: READ, x: 0, y: 1'b0};
endpackage

// File: rtl/compound_rr_arbiter_if.sv
// compound_rr_arbiter_if: requester-side and downstream sync/notify bundle of the arbiter.
interface compound_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import compound_pkg::*;
    CompoundType        req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_sync;
    logic [NUM_REQ-1:0] req_notify;
    CompoundType        out_data;
    logic               out_sync;
    logic               out_notify;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    modport master (
        input  req_data, req_sync, out_sync,
        output req_notify, out_data, out_notify, grant_id, busy
    );
    modport slave (
        output req_data, req_sync, out_sync,
        input  req_notify, out_data, out_notify, grant_id, busy
    );
endinterface

// File: rtl/compound_rr_arbiter_rr_pick.sv
// rr_pick: first set request at or after start, wrapping; rotate, priority-encode, un-rotate.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   p;
    logic [W:0]     sum;
    always_comb begin
        dbl = {req, req} >> start;
        rot = dbl[N-1:0];
        p = '0;
        for (int i = N - 1; i >= 0; i--) p = rot[i] ? W'(i) : p;
        sum = {1'b0, p} + {1'b0, start};
        idx = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : W'(sum);
    end
    assign valid = |req;
endmodule

// File: rtl/compound_rr_arbiter.sv
// compound_rr_arbiter: round-robin arbiter sharing one CompoundType consumer among NUM_REQ
// sync/notify producers, with optional write-first priority.
module compound_rr_arbiter
    import compound_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WRITE_PRIORITY = 1,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input logic                    clk,
    input logic                    rst,
    compound_rr_arbiter_if.master  bus
);
    arb_state_t         state;
    logic [ID_W-1:0]    rr_ptr, grant_id, win;
    logic [NUM_REQ-1:0] wr, cand, req_notify;
    logic               win_valid, out_notify, busy;
    CompoundType        out_data;
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_REQ; i++) wr[i] = bus.req_sync[i] && bus.req_data[i].mode == WRITE;
        cand = (WRITE_PRIORITY != 0 && |wr) ? wr : bus.req_sync;
    end
    rr_pick #(.N(NUM_REQ), .W(ID_W)) pick (
        .req   (cand),
        .start (rr_ptr),
        .idx   (win),
        .valid (win_valid)
    );
    // Withdrawal in ACCEPT leaves rr_ptr alone so the same requester keeps its turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            rr_ptr     <= '0;
            grant_id   <= '0;
            req_notify <= '0;
            out_notify <= 1'b0;
            busy       <= 1'b0;
            out_data   <= COMPOUND_RESET;
        end else begin
            case (state)
                SCAN: if (win_valid) begin
                    grant_id   <= win;
                    req_notify <= NUM_REQ'(1) << win;
                    busy       <= 1'b1;
                    state      <= ACCEPT;
                end
                ACCEPT: begin
                    req_notify <= '0;
                    if (bus.req_sync[grant_id]) begin
                        out_data   <= bus.req_data[grant_id];
                        out_notify <= 1'b1;
                        state      <= SEND;
                    end else begin
                        busy  <= 1'b0;
                        state <= SCAN;
                    end
                end
                SEND: if (bus.out_sync) begin
                    out_notify <= 1'b0;
                    busy       <= 1'b0;
                    rr_ptr     <= grant_id == ID_W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                    state      <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end
    assign bus.req_notify = req_notify;
    assign bus.out_notify = out_notify;
    assign bus.out_data   = out_data;
    assign bus.grant_id   = grant_id;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_compound_rr_arbiter.sv
// tb_compound_rr_arbiter: directed and randomized transactions checked against a
// round-robin/write-priority reference model.
module tb_compound_rr_arbiter;
    import compound_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   mptr = 0;
    compound_rr_arbiter_if #(.NUM_REQ(4)) bus ();
    compound_rr_arbiter #(.NUM_REQ(4), .WRITE_PRIORITY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic int pick(input logic [3:0] s);
        logic [3:0] w = '0;
        for (int i = 0; i < 4; i++) if (s[i] && bus.req_data[i].mode == WRITE) w[i] = 1'b1;
        if (w != 0) s = w;
        for (int k = 0; k < 4; k++) if (s[(mptr + k) % 4]) return (mptr + k) % 4;
        return -1;
    endfunction
    task automatic setd(input int i, input mode_t m, input int x, input logic y);
        bus.req_data[i] = '{mode: m, x: x, y: y};
    endtask
    task automatic rand_data();
        for (int i = 0; i < 4; i++) setd(i, mode_t'($urandom_range(0, 1)), int'($urandom), 1'($urandom));
    endtask
    // One transaction starting at a negedge with the arbiter idle in SCAN.
    task automatic txn(input logic [3:0] s, input bit wd, input int bp, input int exp_w);
        int w;
        time t0;
        CompoundType d;
        t0 = $time;
        bus.req_sync = s;
        w = pick(s);
        if (exp_w >= 0) chk("model_winner", 64'(w), 64'(exp_w));
        d = bus.req_data[w];
        @(negedge clk);
        chk("accept_notify", 64'(bus.req_notify), 64'(4'b1 << w));
        chk("accept_grant", 64'(bus.grant_id), 64'(w));
        chk("accept_busy", 64'(bus.busy), 64'(1));
        chk("accept_out_notify", 64'(bus.out_notify), 64'(0));
        if (wd) begin
            bus.req_sync[w] = 1'b0;
            @(negedge clk);
            chk("withdraw_busy", 64'(bus.busy), 64'(0));
            chk("withdraw_notify", 64'(bus.req_notify), 64'(0));
            chk("withdraw_out_notify", 64'(bus.out_notify), 64'(0));
            return;
        end
        @(negedge clk);
        chk("send_out_notify", 64'(bus.out_notify), 64'(1));
        chk("send_data", 64'(bus.out_data), 64'(d));
        chk("send_req_notify", 64'(bus.req_notify), 64'(0));
        for (int c = 0; c < bp; c++) begin
            bus.out_sync = 1'b0;
            bus.req_sync = 4'($urandom);
            bus.req_data[$urandom_range(0, 3)].x = int'($urandom);
            @(negedge clk);
            chk("bp_out_notify", 64'(bus.out_notify), 64'(1));
            chk("bp_data", 64'(bus.out_data), 64'(d));
            chk("bp_req_notify", 64'(bus.req_notify), 64'(0));
            chk("bp_grant", 64'(bus.grant_id), 64'(w));
        end
        bus.out_sync = 1'b1;
        @(negedge clk);
        chk("done_out_notify", 64'(bus.out_notify), 64'(0));
        chk("done_busy", 64'(bus.busy), 64'(0));
        chk("txn_cycles", 64'(($time - t0) / 10), 64'(3 + bp));
        mptr = (w + 1) % 4;
    endtask
    initial begin
        bus.req_sync = '0;
        bus.out_sync = 1'b1;
        for (int i = 0; i < 4; i++) setd(i, READ, i + 1, 1'b0);
        #1;
        chk("rst_notify", 64'(bus.req_notify), 64'(0));
        chk("rst_out_notify", 64'(bus.out_notify), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_grant", 64'(bus.grant_id), 64'(0));
        chk("rst_data", 64'(bus.out_data), 64'(COMPOUND_RESET));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'(0));
        txn(4'b1111, 0, 0, 0);
        txn(4'b1111, 0, 0, 1);
        txn(4'b1111, 0, 0, 2);
        txn(4'b1111, 0, 0, 3);
        txn(4'b1111, 0, 0, 0);
        txn(4'b0010, 1, 0, 1);
        bus.req_sync = '0;
        @(negedge clk);
        txn(4'b1110, 0, 0, 1);
        setd(2, WRITE, 32'h55, 1'b1);
        txn(4'b0100, 0, 0, 2);
        chk("single_data", 64'(bus.out_data), 64'({WRITE, 32'h55, 1'b1}));
        setd(2, READ, 7, 1'b0);
        txn(4'b1111, 0, 0, 3);
        setd(3, WRITE, 33, 1'b1);
        txn(4'b1001, 0, 0, 3);
        txn(4'b0001, 0, 0, 0);
        txn(4'b0110, 0, 5, 1);
        bus.req_sync = 4'b0100;
        bus.out_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_out_notify", 64'(bus.out_notify), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_out_notify", 64'(bus.out_notify), 64'(0));
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_data", 64'(bus.out_data), 64'(COMPOUND_RESET));
        chk("arst_grant", 64'(bus.grant_id), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.out_sync = 1'b1;
        mptr = 0;
        txn(4'b1010, 0, 0, -1);
        repeat (60) begin
            rand_data();
            bus.out_sync = 1'($urandom);
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 7) == 0, $urandom_range(0, 3), -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
